pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 166 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Instruction sequencer for a simple multi-cycle core. It walks every
// instruction through three phases:
//   IF   - present pc as the fetch address until memory accepts it
//   IW   - wait for the fetched instruction to come back
//   EX   - pulse exec_start once, then wait for the datapath's exec_done
// When exec_done arrives the next pc is chosen with priority
// jalr > jal > br_taken > sequential. A target that is not word aligned
// raises the sticky misalign fault and parks the sequencer in HALT until
// reset. Otherwise the target is loaded into pc and instret advances.
//
// Ports
//   clk, rst          : clock; synchronous active-high reset
//   inst_req_valid    : out, fetch request valid (high only in IF)
//   inst_req_ready    : in,  memory accepts the fetch request
//   inst_addr         : out, fetch address (always equal to pc)
//   inst_valid        : in,  fetched instruction returned
//   inst_ready        : out, sequencer accepts the instruction (only in IW)
//   exec_start        : out, one-cycle pulse on the first EX cycle
//   exec_done         : in,  datapath finished; redirect inputs valid
//   br_taken/jal/jalr : in,  control-flow outcome of current instruction
//   imm, rs1_data     : in,  sign-extended immediate, jalr base register
//   pc                : out, current pc register
//   misalign          : out, sticky misaligned-target fault
//   instret           : out, retired-instruction counter
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req_valid,
    input  logic        inst_req_ready,
    output logic [31:0] inst_addr,
    input  logic        inst_valid,
    output logic        inst_ready,
    output logic        exec_start,
    input  logic        exec_done,
    input  logic        br_taken,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic [31:0] pc,
    output logic        misalign,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        ST_IF   = 2'd0,
        ST_IW   = 2'd1,
        ST_EX   = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] instret_r;
    logic [31:0] instret_s;
    logic        misalign_r;
    logic        misalign_s;
    logic        exec_start_r;
    logic        exec_start_s;
    logic [31:0] target_s;

    // A fetch target must be word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // Redirect target selection; jalr clears bit 0 of its sum before use.
    always_comb begin
        target_s = pc_r + 32'd4;
        if (jalr) begin
            target_s = (rs1_data + imm) & 32'hFFFF_FFFE;
        end else if (jal) begin
            target_s = pc_r + imm;
        end else if (br_taken) begin
            target_s = pc_r + imm;
        end else begin
            target_s = pc_r + 32'd4;
        end
    end

    // Next-state and next-register logic. Handshake inputs are only looked
    // at inside the state that owns them, so stray activity is ignored.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        instret_s    = instret_r;
        misalign_s   = misalign_r;
        exec_start_s = 1'b0;
        case (state_r)
            ST_IF: begin
                if (inst_req_ready) begin
                    state_s = ST_IW;
                end else begin
                    state_s = ST_IF;
                end
            end
            ST_IW: begin
                if (inst_valid) begin
                    state_s      = ST_EX;
                    // Registered pulse lands on the first EX cycle only.
                    exec_start_s = 1'b1;
                end else begin
                    state_s = ST_IW;
                end
            end
            ST_EX: begin
                if (exec_done) begin
                    if (is_misaligned(target_s)) begin
                        misalign_s = 1'b1;
                        state_s    = ST_HALT;
                    end else begin
                        pc_s      = target_s;
                        instret_s = instret_r + 32'd1;
                        state_s   = ST_IF;
                    end
                end else begin
                    state_s = ST_EX;
                end
            end
            ST_HALT: begin
                state_s = ST_HALT;
            end
            default: begin
                state_s = ST_IF;
            end
        endcase
    end

    // State and architectural registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IF;
            pc_r         <= RESET_PC;
            instret_r    <= 32'd0;
            misalign_r   <= 1'b0;
            exec_start_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            instret_r    <= instret_s;
            misalign_r   <= misalign_s;
            exec_start_r <= exec_start_s;
        end
    end

    // Handshake strobes are pure state decodes, independent of any input.
    always_comb begin
        inst_req_valid = (state_r == ST_IF);
        inst_ready     = (state_r == ST_IW);
    end

    assign inst_addr  = pc_r;
    assign pc         = pc_r;
    assign instret    = instret_r;
    assign misalign   = misalign_r;
    assign exec_start = exec_start_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Open-loop driver: each instruction is described by its stall counts and
// control-flow outcome, and the driver plays the matching input waveform
// (with random noise on inputs the sequencer must ignore). A reference model
// computes the next pc / instret / fault with plain arithmetic and pushes the
// expectations into queues. A monitor, sampling just before each rising edge,
// consumes those expectations whenever the DUT presents a fetch handshake,
// re-enters fetch after retiring, or raises misalign.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic [31:0] inst_addr;
    logic        inst_valid;
    logic        inst_ready;
    logic        exec_start;
    logic        exec_done;
    logic        br_taken;
    logic        jal;
    logic        jalr;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] pc;
    logic        misalign;
    logic [31:0] instret;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_req_valid (inst_req_valid),
        .inst_req_ready (inst_req_ready),
        .inst_addr      (inst_addr),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .exec_start     (exec_start),
        .exec_done      (exec_done),
        .br_taken       (br_taken),
        .jal            (jal),
        .jalr           (jalr),
        .imm            (imm),
        .rs1_data       (rs1_data),
        .pc             (pc),
        .misalign       (misalign),
        .instret        (instret)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instret;
        logic        mis;
    } exp_t;

    exp_t        rq[$];      // expected architectural state after each instruction
    logic [31:0] fq[$];      // expected fetch address of each instruction
    int          rq_idx = 0;
    int          fq_idx = 0;

    int tests = 0;
    int fails = 0;

    bit          mon_en    = 1'b0;
    bit          final_req = 1'b0;
    bit          mon_done  = 1'b0;
    logic [31:0] m_pc;
    logic [31:0] m_instret;

    function automatic logic rb();
        return ($urandom & 32'h1) != 32'h0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One driven cycle; redirect inputs get noise unless overridden afterwards.
    task automatic cyc(input logic rr, input logic iv, input logic ed);
        @(negedge clk);
        inst_req_ready = rr;
        inst_valid     = iv;
        exec_done      = ed;
        br_taken       = rb();
        jal            = rb();
        jalr           = rb();
        imm            = $urandom;
        rs1_data       = $urandom;
    endtask

    task automatic run_instr(input int a, input int b, input int c,
                             input logic br_i, input logic jal_i, input logic jalr_i,
                             input logic [31:0] imm_i, input logic [31:0] rs1_i,
                             input logic do_rst);
        logic [31:0] t;
        exp_t        e;
        if (jalr_i)             t = (rs1_i + imm_i) & 32'hFFFF_FFFE;
        else if (jal_i || br_i) t = m_pc + imm_i;
        else                    t = m_pc + 32'd4;
        fq.push_back(m_pc);
        if (!do_rst) begin
            if ((t & 32'h3) != 32'h0) begin
                e.pc = m_pc; e.instret = m_instret; e.mis = 1'b1;
            end else begin
                m_pc = t; m_instret = m_instret + 32'd1;
                e.pc = m_pc; e.instret = m_instret; e.mis = 1'b0;
            end
            rq.push_back(e);
        end
        for (int i = 0; i < a; i++) cyc(1'b0, rb(), rb());
        cyc(1'b1, rb(), rb());
        for (int i = 0; i < b; i++) cyc(rb(), 1'b0, rb());
        cyc(rb(), 1'b1, rb());
        for (int i = 0; i < c; i++) cyc(rb(), rb(), 1'b0);
        cyc(rb(), rb(), 1'b1);
        br_taken = br_i; jal = jal_i; jalr = jalr_i; imm = imm_i; rs1_data = rs1_i;
        if (do_rst) begin
            rst    = 1'b1;
            mon_en = 1'b0;
        end
    endtask

    task automatic rand_instr();
        logic [31:0] im;
        logic [31:0] r1;
        im = 32'($urandom_range(0, 63)) * 32'd4 - 32'd128;
        r1 = ($urandom & 32'hFFFF_FFFC) | ($urandom & 32'h1);
        run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, im, r1, 1'b0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0; inst_req_ready = 1'b0; inst_valid = 1'b0; exec_done = 1'b0;
        m_pc = RESET_PC; m_instret = 32'd0;
        mon_en = 1'b1;
    endtask

    task automatic do_reset();
        cyc(rb(), rb(), 1'b1);
        rst = 1'b1; mon_en = 1'b0;
        release_reset();
    endtask

    // Stimulus sequence.
    initial begin
        rst = 1'b0; inst_req_ready = 1'b0; inst_valid = 1'b0; exec_done = 1'b0;
        br_taken = 1'b0; jal = 1'b0; jalr = 1'b0; imm = 32'd0; rs1_data = 32'd0;
        m_pc = RESET_PC; m_instret = 32'd0;
        repeat (2) @(negedge clk);
        do_reset();
        repeat (3) run_instr(0, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        run_instr(0, 0, 0, 1'b0, 1'b1, 1'b0, 32'h10 - m_pc, 32'd0, 1'b0);
        run_instr(0, 0, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'd0, 1'b0);
        repeat (2) run_instr(0, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        run_instr(0, 0, 0, 1'b1, 1'b1, 1'b1, 32'h3, 32'h101, 1'b0);
        run_instr(4, 2, 5, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        run_instr(1, 0, 2, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC - m_pc, 32'd0, 1'b0);
        run_instr(0, 1, 0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (60) rand_instr();
        run_instr(1, 1, 1, 1'b0, 1'b1, 1'b0, 32'h40, 32'd0, 1'b1);
        release_reset();
        run_instr(0, 0, 0, 1'b0, 1'b1, 1'b0, 32'h2, 32'd0, 1'b0);
        repeat (8) cyc(rb(), rb(), rb());
        do_reset();
        repeat (20) rand_instr();
        run_instr(2, 1, 0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0000_1002, 1'b0);
        repeat (8) cyc(rb(), rb(), rb());
        @(negedge clk);
        final_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    bit   prev_en  = 1'b0;
    logic prev_rv  = 1'b1;
    logic prev_mis = 1'b0;
    bit   halted   = 1'b0;
    int   start_cnt = 0;

    // Monitor: samples 1 time unit before each rising edge.
    always @(negedge clk) begin
        exp_t e;
        #4;
        if (!mon_en) begin
            if (prev_en) begin
                check("retire_drained_at_reset", 32'(rq.size() - rq_idx), 32'd0);
                check("fetch_drained_at_reset", 32'(fq.size() - fq_idx), 32'd0);
                rq_idx = rq.size();
                fq_idx = fq.size();
            end
            prev_en = 1'b0; prev_rv = 1'b1; prev_mis = 1'b0; halted = 1'b0; start_cnt = 0;
        end else if (!prev_en) begin
            check("reset_pc", pc, RESET_PC);
            check("reset_instret", instret, 32'd0);
            check("reset_flags", {28'd0, misalign, inst_req_valid, inst_ready, exec_start},
                  32'h0000_0004);
            prev_en = 1'b1; prev_rv = inst_req_valid; prev_mis = misalign;
        end else begin
            if (exec_start) start_cnt++;
            if (inst_req_valid && fq_idx < fq.size()) check("inst_addr", inst_addr, fq[fq_idx]);
            if (inst_req_valid && inst_req_ready) begin
                if (fq_idx < fq.size()) begin
                    fq_idx++;
                end else begin
                    tests++; fails++;
                    $display("FAIL unexpected_fetch: got handshake at %h expected none", inst_addr);
                end
            end
            if ((inst_req_valid && !prev_rv) || (misalign && !prev_mis)) begin
                if (rq_idx < rq.size()) begin
                    e = rq[rq_idx];
                    rq_idx++;
                    check("retire_pc", pc, e.pc);
                    check("retire_instret", instret, e.instret);
                    check("retire_misalign", {31'd0, misalign}, {31'd0, e.mis});
                    check("exec_start_pulses", 32'(start_cnt), 32'd1);
                    start_cnt = 0;
                    if (e.mis) halted = 1'b1;
                end else begin
                    tests++; fails++;
                    $display("FAIL unexpected_retire: got pc %h expected no retire", pc);
                end
            end
            if (halted) check("halt_outputs", {29'd0, inst_req_valid, inst_ready, exec_start}, 32'd0);
            prev_rv = inst_req_valid; prev_mis = misalign;
        end
        if (final_req && !mon_done) begin
            check("final_retire_drained", 32'(rq.size() - rq_idx), 32'd0);
            check("final_fetch_drained", 32'(fq.size() - fq_idx), 32'd0);
            mon_done = 1'b1;
        end
    end

endmodule
